// File: rtl/mm_pkg.sv
// Shared types for the systolic-array operand path.
// Bank states and the default operand beat layout.
package mm_pkg;

    localparam int MM_DATA_WIDTH = 8;
    localparam int MM_N          = 4;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    typedef struct packed {
        logic [MM_N-1:0][MM_DATA_WIDTH-1:0] a;
        logic [MM_N-1:0][MM_DATA_WIDTH-1:0] b;
    } operand_beat_t;

endpackage

// File: rtl/mm_operand_streamer_bank.sv
// One operand bank: MAX_K beat register file, job length and fill/drain state.
// Reads are combinational so the streamer presents data with zero latency.
module operand_bank
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = MM_DATA_WIDTH,
    parameter int N          = MM_N,
    parameter int MAX_K      = 16,
    parameter int IDX_BITS   = $clog2(MAX_K + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic                           wr_close,
    input  logic [IDX_BITS-1:0]            wr_idx,
    input  logic [N-1:0][DATA_WIDTH-1:0]   wr_a,
    input  logic [N-1:0][DATA_WIDTH-1:0]   wr_b,
    input  logic                           rd_xfer,
    input  logic                           rd_last,
    input  logic [IDX_BITS-1:0]            rd_idx,
    output logic [N-1:0][DATA_WIDTH-1:0]   rd_a,
    output logic [N-1:0][DATA_WIDTH-1:0]   rd_b,
    output logic [IDX_BITS-1:0]            len,
    output bank_state_t                    state
);

    localparam int AW = $clog2(MAX_K);

    logic [N-1:0][DATA_WIDTH-1:0] mem_a [MAX_K];
    logic [N-1:0][DATA_WIDTH-1:0] mem_b [MAX_K];
    bank_state_t                  state_nx;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[wr_idx[AW-1:0]] <= wr_a;
            mem_b[wr_idx[AW-1:0]] <= wr_b;
        end
    end

    assign rd_a = mem_a[rd_idx[AW-1:0]];
    assign rd_b = mem_b[rd_idx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            len   <= '0;
        end else begin
            state <= state_nx;
            if (wr_en && wr_close)
                len <= wr_idx + IDX_BITS'(1);
        end
    end

    // A one-beat job can skip FILLING on load and DRAINING on stream.
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY:    if (wr_en) state_nx = wr_close ? FULL : FILLING;
            FILLING:  if (wr_en && wr_close) state_nx = FULL;
            FULL:     if (rd_xfer) state_nx = rd_last ? EMPTY : DRAINING;
            DRAINING: if (rd_xfer && rd_last) state_nx = EMPTY;
            default:  state_nx = EMPTY;
        endcase
    end

endmodule

// File: rtl/mm_operand_streamer.sv
// Ping-pong operand buffer feeding A columns / B rows into the systolic array.
// The host fills one bank while the other drains with valid/ready/last.
module mm_operand_streamer
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = MM_DATA_WIDTH,
    parameter int N          = MM_N,
    parameter int MAX_K      = 16,
    parameter int IDX_BITS   = $clog2(MAX_K + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic                           ld_last,
    input  logic [N-1:0][DATA_WIDTH-1:0]   ld_a_col,
    input  logic [N-1:0][DATA_WIDTH-1:0]   ld_b_row,
    output logic                           a_valid,
    output logic                           b_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [N-1:0][DATA_WIDTH-1:0]   a_data,
    output logic [N-1:0][DATA_WIDTH-1:0]   b_data,
    output logic                           ovf_err
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(MAX_K - 1);

    logic                         wr_bank;
    logic                         rd_bank;
    logic [IDX_BITS-1:0]          wr_idx;
    logic [IDX_BITS-1:0]          rd_idx;
    bank_state_t                  state [2];
    logic [IDX_BITS-1:0]          len [2];
    logic [N-1:0][DATA_WIDTH-1:0] rd_a [2];
    logic [N-1:0][DATA_WIDTH-1:0] rd_b [2];
    logic                         ld_fire;
    logic                         close;
    logic                         valid;
    logic                         xfer;

    for (genvar i = 0; i < 2; i++) begin : g_bank
        operand_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .N          (N),
            .MAX_K      (MAX_K),
            .IDX_BITS   (IDX_BITS)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (ld_fire && (wr_bank == 1'(i))),
            .wr_close (close),
            .wr_idx   (wr_idx),
            .wr_a     (ld_a_col),
            .wr_b     (ld_b_row),
            .rd_xfer  (xfer && (rd_bank == 1'(i))),
            .rd_last  (out_last),
            .rd_idx   (rd_idx),
            .rd_a     (rd_a[i]),
            .rd_b     (rd_b[i]),
            .len      (len[i]),
            .state    (state[i])
        );
    end

    assign ld_ready = (state[wr_bank] == EMPTY) || (state[wr_bank] == FILLING);
    assign ld_fire  = ld_valid && ld_ready;
    assign close    = ld_fire && (ld_last || (wr_idx == LAST_IDX));

    // Valid comes from bank state only, never from out_ready.
    assign valid    = (state[rd_bank] == FULL) || (state[rd_bank] == DRAINING);
    assign a_valid  = valid;
    assign b_valid  = valid;
    assign out_last = valid && (rd_idx == len[rd_bank] - IDX_BITS'(1));
    assign a_data   = valid ? rd_a[rd_bank] : '0;
    assign b_data   = valid ? rd_b[rd_bank] : '0;
    assign xfer     = valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            ovf_err <= 1'b0;
        end else begin
            ovf_err <= ld_fire && (wr_idx == LAST_IDX) && !ld_last;
            if (ld_fire)
                wr_idx <= close ? '0 : wr_idx + IDX_BITS'(1);
            if (close)
                wr_bank <= ~wr_bank;
            if (xfer) begin
                rd_idx <= out_last ? '0 : rd_idx + IDX_BITS'(1);
                if (out_last)
                    rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_mm_operand_streamer.sv
// Bench for mm_operand_streamer: cycle table plus scoreboarded job sequences.
module tb_mm_operand_streamer;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int MAX_K = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               ld_valid;
    logic               ld_ready;
    logic               ld_last;
    logic [N-1:0][DW-1:0] ld_a_col;
    logic [N-1:0][DW-1:0] ld_b_row;
    logic               a_valid;
    logic               b_valid;
    logic               out_ready;
    logic               out_last;
    logic [N-1:0][DW-1:0] a_data;
    logic [N-1:0][DW-1:0] b_data;
    logic               ovf_err;

    mm_operand_streamer #(
        .DATA_WIDTH (DW),
        .N          (N),
        .MAX_K      (MAX_K)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_last   (ld_last),
        .ld_a_col  (ld_a_col),
        .ld_b_row  (ld_b_row),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .a_data    (a_data),
        .b_data    (b_data),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
    } exp_t;

    typedef struct {
        logic ld_valid;
        logic ld_last;
        logic out_ready;
        logic exp_ld_ready;
        logic exp_valid;
        logic exp_last;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    seq = 0;
    int    wcnt = 0;
    int    xfers = 0;
    int    cyc = 0;
    int    xcyc[$];
    exp_t  q[$];
    logic  hold_v = 1'b0;
    logic [64:0] held;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input int k);
        for (int j = 0; j < N; j++) begin
            ld_a_col[j] = DW'(k + 1 + 16 * j);
            ld_b_row[j] = DW'(10 * k + j);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: push on accepted load, pop and compare on transfer.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            wcnt   = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 128'(a_valid), 128'(1));
                check("hold_beat", 128'({a_data, b_data, out_last}), 128'(held));
            end
            hold_v = a_valid && !out_ready;
            if (hold_v)
                held = {a_data, b_data, out_last};
            if (ld_valid && ld_ready) begin
                exp_t e;
                e.a    = ld_a_col;
                e.b    = ld_b_row;
                e.last = ld_last || (wcnt == MAX_K - 1);
                q.push_back(e);
                wcnt = e.last ? 0 : wcnt + 1;
            end
            if (a_valid && out_ready) begin
                xfers++;
                xcyc.push_back(cyc);
                if (q.size() == 0) begin
                    check("unexpected_beat", 128'(a_data), 128'(0) + 128'(1) << 100);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("a_data", 128'(a_data), 128'(e.a));
                    check("b_data", 128'(b_data), 128'(e.b));
                    check("out_last", 128'(out_last), 128'(e.last));
                    check("b_valid", 128'(b_valid), 128'(1));
                end
            end
        end
    end

    task automatic load_job(input int k, input bit use_last, output int stalls);
        stalls = 0;
        for (int i = 0; i < k; i++) begin
            ld_valid = 1'b1;
            ld_last  = use_last && (i == k - 1);
            set_beat(seq);
            seq++;
            @(negedge clk);
            while (!ld_ready && stalls < 64) begin
                stalls++;
                @(negedge clk);
            end
            if (!ld_ready)
                check("load_timeout", 128'(ld_ready), 128'(1));
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(q.size() == 0 && !a_valid) && n < 300);
        check("drain_done", 128'(q.size() == 0 && !a_valid), 128'(1));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        int st;
        int st2;
        int x0;
        int n0;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        out_ready = 1'b0;
        ld_a_col  = '0;
        ld_b_row  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ld_ready", 128'(ld_ready), 128'(1));
        check("rst_a_valid", 128'(a_valid), 128'(0));
        check("rst_b_valid", 128'(b_valid), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_ovf", 128'(ovf_err), 128'(0));
        check("rst_a_data", 128'(a_data), 128'(0));
        check("rst_b_data", 128'(b_data), 128'(0));
        @(posedge clk);
        #1;

        // Cycle table: K=2 job, then K=1 jobs interleaved with drain.
        for (int r = 0; r < 8; r++) begin
            ld_valid  = tbl[r].ld_valid;
            ld_last   = tbl[r].ld_last;
            out_ready = tbl[r].out_ready;
            set_beat(seq);
            seq++;
            @(negedge clk);
            check($sformatf("tbl%0d_ld_ready", r), 128'(ld_ready), 128'(tbl[r].exp_ld_ready));
            check($sformatf("tbl%0d_valid", r), 128'(a_valid), 128'(tbl[r].exp_valid));
            check($sformatf("tbl%0d_last", r), 128'(out_last), 128'(tbl[r].exp_last));
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        // Basic K=4 job.
        seq = 0;
        out_ready = 1'b0;
        x0 = xfers;
        load_job(4, 1'b1, st);
        drain();
        check("t1_beats", 128'(xfers - x0), 128'(4));

        // Stall mid-job for five cycles.
        out_ready = 1'b0;
        x0 = xfers;
        load_job(4, 1'b1, st);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        drain();
        check("t2_beats", 128'(xfers - x0), 128'(4));

        // Load job B while job A drains: no gap, no load stall.
        out_ready = 1'b1;
        n0 = xcyc.size();
        load_job(4, 1'b1, st);
        load_job(2, 1'b1, st2);
        check("t3_stall_a", 128'(st), 128'(0));
        check("t3_stall_b", 128'(st2), 128'(0));
        drain();
        check("t3_beats", 128'(xcyc.size() - n0), 128'(6));
        if (xcyc.size() - n0 == 6)
            check("t3_no_gap", 128'(xcyc[n0 + 5] - xcyc[n0]), 128'(5));

        // Both banks busy: host stalls until job 1 frees its bank.
        out_ready = 1'b0;
        load_job(2, 1'b1, st);
        load_job(2, 1'b1, st);
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        set_beat(seq);
        seq++;
        @(negedge clk);
        check("t4_stall0", 128'(ld_ready), 128'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_stall1", 128'(ld_ready), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_stall2", 128'(ld_ready), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_rise", 128'(ld_ready), 128'(1));
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        drain();

        // 17 beats without last: truncation at MAX_K.
        out_ready = 1'b0;
        x0 = xfers;
        for (int i = 0; i < MAX_K + 1; i++) begin
            ld_valid = 1'b1;
            ld_last  = 1'b0;
            set_beat(seq);
            seq++;
            @(negedge clk);
            check($sformatf("t5_ready%0d", i), 128'(ld_ready), 128'(1));
            @(posedge clk);
            #1;
            check($sformatf("t5_ovf%0d", i), 128'(ovf_err), 128'(i == MAX_K - 1));
        end
        load_job(1, 1'b1, st);
        drain();
        check("t5_beats", 128'(xfers - x0), 128'(MAX_K + 2));

        // Reset mid-drain.
        out_ready = 1'b0;
        load_job(4, 1'b1, st);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("t6_valid", 128'(a_valid), 128'(0));
        check("t6_ld_ready", 128'(ld_ready), 128'(1));
        check("t6_a_data", 128'(a_data), 128'(0));
        @(posedge clk);
        #1;
        x0 = xfers;
        load_job(1, 1'b1, st);
        @(negedge clk);
        check("t6_k1_last", 128'(out_last), 128'(1));
        drain();
        check("t6_beats", 128'(xfers - x0), 128'(1));

        check("sb_empty", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
